// File: rtl/switch_debounce_ctrl.sv
// Slide-switch conditioner: two-flop synchroniser, counter-based debounce FSM,
// registered press/release strobes, toggling LED and a wrapping press counter.
module switch_debounce_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DBC_W           = 20
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSW,
  output logic             oSW_STABLE,
  output logic             oPRESS,
  output logic             oRELEASE,
  output logic             oLED,
  output logic [CNT_W-1:0] oCOUNT
);

  typedef enum logic [1:0] {
    LOW_STABLE,
    WAIT_HIGH,
    HIGH_STABLE,
    WAIT_LOW
  } state_e;

  localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBC_W-1:0] CNT_ONE  = DBC_W'(1);

  logic             s1_q;
  logic             sync_q;
  state_e           state_q, state_d;
  logic [DBC_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_q     <= 1'b0;
      sync_q   <= 1'b0;
      state_q  <= LOW_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      led_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_q     <= iSW;
      sync_q   <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      led_q    <= led_d;
      count_q  <= count_d;
    end
  end

  // The counter already holds 1 on entry to a WAIT state, so reaching
  // DEBOUNCE_CYCLES-1 there means DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      LOW_STABLE: begin
        if (sync_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q)       state_d = LOW_STABLE;
        else if (cnt_done) state_d = HIGH_STABLE;
        else               cnt_d   = cnt_q + CNT_ONE;
      end
      HIGH_STABLE: begin
        if (!sync_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_q)        state_d = HIGH_STABLE;
        else if (cnt_done) state_d = LOW_STABLE;
        else               cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = LOW_STABLE;
    endcase
  end

  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    led_d    = led_q;
    count_d  = count_q;
    if (state_q == WAIT_HIGH && sync_q && cnt_done) begin
      stable_d = 1'b1;
      press_d  = 1'b1;
      led_d    = ~led_q;
      count_d  = count_q + 1'b1;
    end else if (state_q == WAIT_LOW && !sync_q && cnt_done) begin
      stable_d = 1'b0;
      rel_d    = 1'b1;
    end
  end

  assign oSW_STABLE = stable_q;
  assign oPRESS     = press_q;
  assign oRELEASE   = rel_q;
  assign oLED       = led_q;
  assign oCOUNT     = count_q;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Scoreboard bench for switch_debounce_ctrl: a run-length reference model
// queues the expected outputs per clock edge; a monitor pops and compares.
module tb_switch_debounce_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iSW = 1'b0;
  logic          oSW_STABLE, oPRESS, oRELEASE, oLED;
  logic [CW-1:0] oCOUNT;

  switch_debounce_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .DBC_W          (3)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iSW       (iSW),
    .oSW_STABLE(oSW_STABLE),
    .oPRESS    (oPRESS),
    .oRELEASE  (oRELEASE),
    .oLED      (oLED),
    .oCOUNT    (oCOUNT)
  );

  always #10 iCLK = ~iCLK;

  typedef struct packed {
    logic          stable;
    logic          press;
    logic          rel;
    logic          led;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seen_presses = 0;

  // Reference model: level history and run length of disagreeing samples.
  bit   hist[$];
  bit   level;
  int   run;
  int   presses;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    level   = 1'b0;
    run     = 0;
    presses = 0;
  endtask

  // Called at a falling edge: drive iSW, predict the next rising edge, wait.
  task automatic step(input bit sw);
    bit   obs;
    exp_t e;
    iSW = sw;
    obs = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
    e.press = 1'b0;
    e.rel   = 1'b0;
    if (obs != level) begin
      run++;
      if (run == DEB) begin
        level = obs;
        run   = 0;
        if (obs) begin
          presses++;
          e.press = 1'b1;
        end else begin
          e.rel = 1'b1;
        end
      end
    end else begin
      run = 0;
    end
    e.stable = level;
    e.led    = presses[0];
    e.count  = CW'(presses % 16);
    exp_q.push_back(e);
    hist.push_back(sw);
    if (hist.size() > 2) void'(hist.pop_front());
    @(negedge iCLK);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_stable"}, int'(oSW_STABLE), 0);
    chk({name, "_press"},  int'(oPRESS),     0);
    chk({name, "_rel"},    int'(oRELEASE),   0);
    chk({name, "_led"},    int'(oLED),       0);
    chk({name, "_count"},  int'(oCOUNT),     0);
  endtask

  task automatic do_reset(input bit sw_during);
    iRST_N = 1'b0;
    iSW    = sw_during;
    #1 chk_zero("rst_async");
    repeat (3) begin
      @(negedge iCLK);
      chk_zero("rst_hold");
    end
    iRST_N = 1'b1;
    model_reset();
  endtask

  always @(posedge iCLK) begin
    exp_t e, a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {oSW_STABLE, oPRESS, oRELEASE, oLED, oCOUNT};
      n_checks++;
      if (a == e) n_pass++;
      else $display("FAIL edge_outputs: got stb=%0b prs=%0b rel=%0b led=%0b cnt=%0d expected stb=%0b prs=%0b rel=%0b led=%0b cnt=%0d at %0t",
                    a.stable, a.press, a.rel, a.led, a.count,
                    e.stable, e.press, e.rel, e.led, e.count, $time);
      n_checks++;
      if (!(oPRESS && oRELEASE)) n_pass++;
      else $display("FAIL strobe_exclusive: got press=1 release=1 expected not both at %0t", $time);
      if (oPRESS) seen_presses++;
    end
  end

  initial begin
    bit sw;
    model_reset();
    @(negedge iCLK);

    // 1: reset held with switch high, then normal debounce of the held level
    do_reset(1'b1);
    repeat (8) step(1'b1);
    chk("t1_stable", int'(oSW_STABLE), 1);
    chk("t1_led",    int'(oLED),       1);
    chk("t1_count",  int'(oCOUNT),     1);

    // 2: clean press then clean release
    do_reset(1'b0);
    repeat (3) step(1'b0);
    repeat (8) step(1'b1);
    chk("t2_press_count", int'(oCOUNT), 1);
    chk("t2_press_led",   int'(oLED),   1);
    repeat (8) step(1'b0);
    chk("t2_rel_stable", int'(oSW_STABLE), 0);
    chk("t2_rel_led",    int'(oLED),       1);
    chk("t2_rel_count",  int'(oCOUNT),     1);

    // 3: bounce rejection then a long hold
    do_reset(1'b0);
    repeat (3) step(1'b1);
    step(1'b0);
    repeat (3) step(1'b1);
    repeat (8) step(1'b0);
    chk("t3_bounce_stable", int'(oSW_STABLE), 0);
    chk("t3_bounce_count",  int'(oCOUNT),     0);
    repeat (10) step(1'b1);
    chk("t3_hold_count", int'(oCOUNT), 1);

    // 4: counter wrap over 17 presses
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      repeat (8) step(1'b1);
      chk("t4_count", int'(oCOUNT), (i + 1) % 16);
      repeat (8) step(1'b0);
    end
    chk("t4_led", int'(oLED), 1);

    // 5: reset between edges mid-debounce, switch still high on release
    repeat (4) step(1'b1);
    do_reset(1'b1);
    repeat (5) step(1'b1);
    chk("t5_no_early_press", int'(oCOUNT), 0);
    repeat (3) step(1'b1);
    chk("t5_count", int'(oCOUNT), 1);

    // 6: random bouncing
    do_reset(1'b0);
    seen_presses = 0;
    sw = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      step(sw);
    end
    chk("t6_count_vs_pulses", int'(oCOUNT), seen_presses % 16);
    chk("t6_led_parity",      int'(oLED),   seen_presses % 2);
    chk("t6_model_presses",   seen_presses, presses);
    chk("t6_queue_drained",   exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
